pattern_gen_anim: RTL and testbench
===================================

Name: pattern_gen_anim

Overview:
Parametrised, animated successor to the static test pattern generator. It sits between the sync/counter generator and the VGA sync-porch stage, driven by the active-area column/row counts.
- Adds three patterns: bouncing box, scrolling colour bars, horizontal ramp.
- Updates the selected pattern only on frame boundaries, so there is no tearing.
- Blanks all channels outside the active area.
- Delays the column/row counts to stay aligned with the video outputs.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel
- ACTIVE_COLS, 640, active pixels per line
- ACTIVE_ROWS, 480, active lines per frame
- COUNT_WIDTH, 10, width of column/row counts
- BOX_SIZE, 32, bouncing box edge in pixels
- BOX_STEP, 2, box displacement per frame in pixels, per axis
- SCROLL_STEP, 4, colour-bar scroll per frame in pixels
- RAMP_SHIFT, 6, column right-shift used for ramp level

Ports:
- i_Clk  in  1  pixel clock (25 MHz for 640x480)
- i_Rst  in  1  synchronous reset, active-high
- i_Pattern  in  4  requested pattern index
- i_Col_Count  in  COUNT_WIDTH  current column, including blanking
- i_Row_Count  in  COUNT_WIDTH  current row, including blanking
- o_Col_Count  out  COUNT_WIDTH  i_Col_Count delayed 2 cycles
- o_Row_Count  out  COUNT_WIDTH  i_Row_Count delayed 2 cycles
- o_Red_Video  out  VIDEO_WIDTH  red
- o_Grn_Video  out  VIDEO_WIDTH  green
- o_Blu_Video  out  VIDEO_WIDTH  blue

Behaviour:
- One clock (i_Clk). Reset is synchronous and active-high (i_Rst). Reset wins over every other event in the same cycle.
- Reset values:
  - all outputs 0
  - pattern register 0
  - box x=0, y=0, direction +x/+y
  - scroll offset 0
  - pipeline registers 0
- Active area: col < ACTIVE_COLS and row < ACTIVE_ROWS. Outside it, RGB = 0 for every pattern.
- Frame tick: internal one-cycle pulse when i_Col_Count==0 and i_Row_Count==ACTIVE_ROWS (first blanking line).
- On each tick:
  - Pattern register latches i_Pattern; indices >9 latch as 0.
  - Box and scroll update as below.
  - i_Pattern changes between ticks are ignored.
- Pattern 0: black.
- Patterns 1/2/3: full red/green/blue.
- Pattern 4: white/black checkerboard, col[5]^row[5].
- Pattern 5: 8 equal static bars (width ACTIVE_COLS/8), bar index b gives R=b[2], G=b[1], B=b[0].
- Pattern 6: black field with a 2-pixel white border.
- Pattern 7: white BOX_SIZE square at (x,y) on a blue field. The box spans x<=col<x+BOX_SIZE and y<=row<y+BOX_SIZE.
  - Per tick, +x: if x+BOX_STEP >= ACTIVE_COLS-BOX_SIZE, then x = ACTIVE_COLS-BOX_SIZE and direction flips to -x; else x += BOX_STEP.
  - Per tick, -x: if x <= BOX_STEP, then x = 0 and direction flips to +x; else x -= BOX_STEP.
  - y behaves identically against ACTIVE_ROWS.
  - Box state updates every tick regardless of the selected pattern.
- Pattern 8: pattern-5 bars evaluated at shifted column s = col+offset, minus ACTIVE_COLS if s >= ACTIVE_COLS.
  - Per tick, offset += SCROLL_STEP.
  - If the result is >= ACTIVE_COLS, subtract ACTIVE_COLS.
- Pattern 9: grey ramp. All channels = min(col>>RAMP_SHIFT, 2^VIDEO_WIDTH-1).
- Pipeline: total latency 2 cycles.
  - Stage 1 registers per-pattern colours and the active flag.
  - Stage 2 registers the selected RGB.
  - o_Col_Count/o_Row_Count pass through 2 matching delay registers.
- All arithmetic uses COUNT_WIDTH+1 bits internally, so nothing overflows before comparison.

Optional Feature:
PATTERN_GEN_CROSSHAIR_EN
- Defined: for patterns 1-9, pixels with col==ACTIVE_COLS/2 or row==ACTIVE_ROWS/2 (active area only) are forced to white in stage 2. Latency is unchanged.
- Undefined: no overlay logic.

Decomposition:
- Package pattern_gen_pkg:
  - pattern index constants PAT_BLACK..PAT_RAMP (0-9)
  - PAT_COUNT=10
  - 3-bit bar-colour truth-table function
- Sub-module pattern_gen_box_ctrl: owns the box position/direction state machine. Inputs i_Clk, i_Rst, frame tick; outputs x, y.

Test Plan:
- Reset mid-frame with pattern 5 streaming -> next cycle RGB=0; 2 cycles after release, outputs follow the pattern-0 path until the first tick.
- i_Pattern 0->1 at row 100 -> RGB stays 0 until the tick at row 480, col 0; row 0 col 0 of the next frame shows R=7, G=0, B=0 exactly 2 cycles after its inputs.
- Pattern 7 for 320 frames, defaults -> x reaches 608 at frame 304 and the direction flips; then x=606. y peaks at 448 at frame 224.
- Pattern 8: after 1 tick, col 0 is black and col 76 is blue (s=80). After 160 ticks, offset wraps to 0.
- Pattern 9: col 0 -> 0, col 64 -> 1, col 448 -> 7, col 639 -> 7 (saturated). Col 640 -> 0 (blank).
- Pattern 12 requested -> latched as 0, all outputs black. o_Col_Count equals i_Col_Count delayed exactly 2 cycles throughout.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: pattern indices and the bar-colour truth table shared by the animated pattern generator.
package pattern_gen_pkg;
    localparam logic [3:0] PAT_BLACK   = 4'd0;
    localparam logic [3:0] PAT_RED     = 4'd1;
    localparam logic [3:0] PAT_GREEN   = 4'd2;
    localparam logic [3:0] PAT_BLUE    = 4'd3;
    localparam logic [3:0] PAT_CHECKER = 4'd4;
    localparam logic [3:0] PAT_BARS    = 4'd5;
    localparam logic [3:0] PAT_BORDER  = 4'd6;
    localparam logic [3:0] PAT_BOX     = 4'd7;
    localparam logic [3:0] PAT_SCROLL  = 4'd8;
    localparam logic [3:0] PAT_RAMP    = 4'd9;
    localparam int         PAT_COUNT   = 10;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_mask_t;

    function automatic rgb_mask_t bar_colour(input logic [2:0] idx);
        bar_colour = {idx[2], idx[1], idx[0]};
    endfunction
endpackage

// File: rtl/pattern_gen_box_ctrl.sv
// pattern_gen_box_ctrl: bouncing-box position and direction, stepped once per frame tick.
module pattern_gen_box_ctrl #(
    parameter int COUNT_WIDTH = 10,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 2
)(
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Tick,
    output logic [COUNT_WIDTH:0] o_X,
    output logic [COUNT_WIDTH:0] o_Y
);
    localparam int CW = COUNT_WIDTH + 1;
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;
    localparam logic [COUNT_WIDTH:0] X_MAX = CW'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [COUNT_WIDTH:0] Y_MAX = CW'(ACTIVE_ROWS - BOX_SIZE);
    localparam logic [COUNT_WIDTH:0] STEP  = CW'(BOX_STEP);

    logic                   r_dir_x, r_dir_y;
    logic [COUNT_WIDTH+1:0] w_next_x, w_next_y;

    // Returns {next direction, next position}; clamps to the edge and reverses on contact.
    function automatic logic [COUNT_WIDTH+1:0] bounce(input logic [COUNT_WIDTH:0] pos,
                                                      input logic dir,
                                                      input logic [COUNT_WIDTH:0] lim);
        if (dir == DIR_POS)
            bounce = (pos + STEP >= lim) ? {DIR_NEG, lim} : {DIR_POS, pos + STEP};
        else
            bounce = (pos <= STEP) ? {DIR_POS, {CW{1'b0}}} : {DIR_NEG, pos - STEP};
    endfunction

    assign w_next_x = bounce(o_X, r_dir_x, X_MAX);
    assign w_next_y = bounce(o_Y, r_dir_y, Y_MAX);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_X     <= '0;
            o_Y     <= '0;
            r_dir_x <= DIR_POS;
            r_dir_y <= DIR_POS;
        end else if (i_Tick) begin
            {r_dir_x, o_X} <= w_next_x;
            {r_dir_y, o_Y} <= w_next_y;
        end
    end
endmodule

// File: rtl/pattern_gen_anim.sv
// pattern_gen_anim: animated test-pattern generator, 2-cycle pipelined RGB with aligned col/row counts.
// Define PATTERN_GEN_CROSSHAIR_EN to overlay a white centre crosshair on patterns 1-9.
module pattern_gen_anim
    import pattern_gen_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int COUNT_WIDTH = 10,
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 2,
    parameter int SCROLL_STEP = 4,
    parameter int RAMP_SHIFT  = 6
)(
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [3:0]             i_Pattern,
    input  logic [COUNT_WIDTH-1:0] i_Col_Count,
    input  logic [COUNT_WIDTH-1:0] i_Row_Count,
    output logic [COUNT_WIDTH-1:0] o_Col_Count,
    output logic [COUNT_WIDTH-1:0] o_Row_Count,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);
    localparam int CW    = COUNT_WIDTH + 1;
    localparam int BAR_W = ACTIVE_COLS / 8;
    localparam logic [VIDEO_WIDTH-1:0] V_FULL = '1;

    logic [COUNT_WIDTH:0]   w_col, w_row, w_box_x, w_box_y;
    logic [COUNT_WIDTH:0]   w_off_sum, w_shift_sum, w_shift, w_ramp_lvl;
    logic                   w_tick, w_active, w_checker, w_border, w_box, w_white;
    logic [2:0]             w_bar, w_scroll_bar;
    logic [VIDEO_WIDTH-1:0] w_ramp, w_red, w_grn, w_blu;
    rgb_mask_t              w_mask;
    logic [3:0]             r_pattern;
    logic [COUNT_WIDTH:0]   r_offset;
    logic                   r_active, r_checker, r_border, r_box;
    logic [2:0]             r_bar, r_scroll_bar;
    logic [VIDEO_WIDTH-1:0] r_ramp;
    logic [COUNT_WIDTH-1:0] r_col_d1, r_row_d1;

    function automatic logic [2:0] bar_of(input logic [COUNT_WIDTH:0] c);
        bar_of = 3'd0;
        for (int k = 1; k < 8; k++)
            if (c >= CW'(k * BAR_W)) bar_of = 3'(k);
    endfunction

    assign w_col       = {1'b0, i_Col_Count};
    assign w_row       = {1'b0, i_Row_Count};
    assign w_tick      = (w_col == '0) && (w_row == CW'(ACTIVE_ROWS));
    assign w_active    = (w_col < CW'(ACTIVE_COLS)) && (w_row < CW'(ACTIVE_ROWS));
    assign w_off_sum   = r_offset + CW'(SCROLL_STEP);
    assign w_shift_sum = w_col + r_offset;
    assign w_shift     = (w_shift_sum >= CW'(ACTIVE_COLS)) ? w_shift_sum - CW'(ACTIVE_COLS) : w_shift_sum;
    assign w_bar        = bar_of(w_col);
    assign w_scroll_bar = bar_of(w_shift);
    assign w_checker   = i_Col_Count[5] ^ i_Row_Count[5];
    assign w_border    = (w_col < CW'(2)) || (w_col >= CW'(ACTIVE_COLS - 2)) ||
                         (w_row < CW'(2)) || (w_row >= CW'(ACTIVE_ROWS - 2));
    assign w_box       = (w_col >= w_box_x) && (w_col < w_box_x + CW'(BOX_SIZE)) &&
                         (w_row >= w_box_y) && (w_row < w_box_y + CW'(BOX_SIZE));
    assign w_ramp_lvl  = w_col >> RAMP_SHIFT;
    assign w_ramp      = (w_ramp_lvl > CW'(V_FULL)) ? V_FULL : w_ramp_lvl[VIDEO_WIDTH-1:0];

    pattern_gen_box_ctrl #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .ACTIVE_COLS (ACTIVE_COLS),
        .ACTIVE_ROWS (ACTIVE_ROWS),
        .BOX_SIZE    (BOX_SIZE),
        .BOX_STEP    (BOX_STEP)
    ) u_box_ctrl (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Tick (w_tick),
        .o_X    (w_box_x),
        .o_Y    (w_box_y)
    );

    // Frame-boundary state plus stage 1: every pattern's colour is precomputed here.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_pattern    <= PAT_BLACK;
            r_offset     <= '0;
            r_active     <= 1'b0;
            r_checker    <= 1'b0;
            r_border     <= 1'b0;
            r_box        <= 1'b0;
            r_bar        <= '0;
            r_scroll_bar <= '0;
            r_ramp       <= '0;
            r_col_d1     <= '0;
            r_row_d1     <= '0;
        end else begin
            if (w_tick) begin
                r_pattern <= (i_Pattern < 4'(PAT_COUNT)) ? i_Pattern : PAT_BLACK;
                r_offset  <= (w_off_sum >= CW'(ACTIVE_COLS)) ? w_off_sum - CW'(ACTIVE_COLS) : w_off_sum;
            end
            r_active     <= w_active;
            r_checker    <= w_checker;
            r_border     <= w_border;
            r_box        <= w_box;
            r_bar        <= w_bar;
            r_scroll_bar <= w_scroll_bar;
            r_ramp       <= w_ramp;
            r_col_d1     <= i_Col_Count;
            r_row_d1     <= i_Row_Count;
        end
    end

`ifdef PATTERN_GEN_CROSSHAIR_EN
    logic r_cross;
    always_ff @(posedge i_Clk) begin
        if (i_Rst) r_cross <= 1'b0;
        else       r_cross <= (w_col == CW'(ACTIVE_COLS / 2)) || (w_row == CW'(ACTIVE_ROWS / 2));
    end
    assign w_white = r_active && r_cross && (r_pattern != PAT_BLACK);
`else
    assign w_white = 1'b0;
`endif

    always_comb begin
        w_mask = '0;
        case (r_pattern)
            PAT_RED:     w_mask = 3'b100;
            PAT_GREEN:   w_mask = 3'b010;
            PAT_BLUE:    w_mask = 3'b001;
            PAT_CHECKER: w_mask = {3{r_checker}};
            PAT_BARS:    w_mask = bar_colour(r_bar);
            PAT_BORDER:  w_mask = {3{r_border}};
            PAT_BOX:     w_mask = r_box ? 3'b111 : 3'b001;
            PAT_SCROLL:  w_mask = bar_colour(r_scroll_bar);
            default:     w_mask = '0;
        endcase
    end

    assign w_red = (r_pattern == PAT_RAMP) ? r_ramp : {VIDEO_WIDTH{w_mask.r}};
    assign w_grn = (r_pattern == PAT_RAMP) ? r_ramp : {VIDEO_WIDTH{w_mask.g}};
    assign w_blu = (r_pattern == PAT_RAMP) ? r_ramp : {VIDEO_WIDTH{w_mask.b}};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Red_Video <= '0;
            o_Grn_Video <= '0;
            o_Blu_Video <= '0;
            o_Col_Count <= '0;
            o_Row_Count <= '0;
        end else begin
            o_Red_Video <= w_white ? V_FULL : (r_active ? w_red : '0);
            o_Grn_Video <= w_white ? V_FULL : (r_active ? w_grn : '0);
            o_Blu_Video <= w_white ? V_FULL : (r_active ? w_blu : '0);
            o_Col_Count <= r_col_d1;
            o_Row_Count <= r_row_d1;
        end
    end
endmodule

// File: tb/tb_pattern_gen_anim.sv
// tb_pattern_gen_anim: randomized stimulus against a frame-level reference model of the animated pattern generator.
module tb_pattern_gen_anim;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pat;
    logic [9:0] col, row;
    logic [9:0] o_col, o_row;
    logic [2:0] o_red, o_grn, o_blu;

    int n_checks = 0;
    int n_errors = 0;

    int m_pat, m_bx, m_by, m_dx, m_dy, m_off;
    logic [8:0] e1_rgb, e2_rgb;
    int e1_col, e2_col, e1_row, e2_row;

    always #20 clk = ~clk;

    pattern_gen_anim dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Pattern   (pat),
        .i_Col_Count (col),
        .i_Row_Count (row),
        .o_Col_Count (o_col),
        .o_Row_Count (o_row),
        .o_Red_Video (o_red),
        .o_Grn_Video (o_grn),
        .o_Blu_Video (o_blu)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (col_in=%0d row_in=%0d pat_model=%0d)",
                     tag, got, exp, col, row, m_pat);
        end
    endtask

    function automatic logic [8:0] bars(input int idx);
        logic [2:0] b;
        b = 3'(idx);
        return {{3{b[2]}}, {3{b[1]}}, {3{b[0]}}};
    endfunction

    function automatic logic [8:0] ref_pixel(input int p, input int c, input int r);
        int lvl;
        if (c >= 640 || r >= 480) return 9'd0;
`ifdef PATTERN_GEN_CROSSHAIR_EN
        if (p != 0 && (c == 320 || r == 240)) return 9'o777;
`endif
        case (p)
            1: return 9'o700;
            2: return 9'o070;
            3: return 9'o007;
            4: return (((c / 32) + (r / 32)) % 2 == 1) ? 9'o777 : 9'o000;
            5: return bars(c / 80);
            6: return (c < 2 || c >= 638 || r < 2 || r >= 478) ? 9'o777 : 9'o000;
            7: return (c >= m_bx && c < m_bx + 32 && r >= m_by && r < m_by + 32) ? 9'o777 : 9'o007;
            8: return bars(((c + m_off) % 640) / 80);
            9: begin
                lvl = c / 64;
                if (lvl > 7) lvl = 7;
                return {3'(lvl), 3'(lvl), 3'(lvl)};
            end
            default: return 9'o000;
        endcase
    endfunction

    task automatic model_frame();
        m_pat = (int'(pat) <= 9) ? int'(pat) : 0;
        if (m_dx > 0) begin
            if (m_bx + 2 >= 608) begin m_bx = 608; m_dx = -1; end else m_bx += 2;
        end else begin
            if (m_bx <= 2) begin m_bx = 0; m_dx = 1; end else m_bx -= 2;
        end
        if (m_dy > 0) begin
            if (m_by + 2 >= 448) begin m_by = 448; m_dy = -1; end else m_by += 2;
        end else begin
            if (m_by <= 2) begin m_by = 0; m_dy = 1; end else m_by -= 2;
        end
        m_off = (m_off + 4) % 640;
    endtask

    task automatic step();
        if (rst) begin
            e1_rgb = '0; e2_rgb = '0;
            e1_col = 0; e2_col = 0; e1_row = 0; e2_row = 0;
            m_pat = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_off = 0;
        end else begin
            e2_rgb = e1_rgb; e2_col = e1_col; e2_row = e1_row;
            e1_rgb = ref_pixel(m_pat, int'(col), int'(row));
            e1_col = int'(col); e1_row = int'(row);
            if (col == 10'd0 && row == 10'd480) model_frame();
        end
        @(posedge clk);
        #1;
        check_eq("red", 32'(o_red), 32'(e2_rgb[8:6]));
        check_eq("grn", 32'(o_grn), 32'(e2_rgb[5:3]));
        check_eq("blu", 32'(o_blu), 32'(e2_rgb[2:0]));
        check_eq("col_delay", 32'(o_col), 32'(e2_col));
        check_eq("row_delay", 32'(o_row), 32'(e2_row));
    endtask

    task automatic pix(input int c, input int r);
        col = 10'(c);
        row = 10'(r);
        step();
    endtask

    task automatic tick();
        pix(0, 480);
    endtask

    task automatic rand_pix();
        pix($urandom_range(0, 700), $urandom_range(0, 520));
    endtask

    initial begin
        rst = 1'b1; pat = 4'd0; col = '0; row = '0;
        step(); step();
        rst = 1'b0;
        repeat (3) rand_pix();
        // pattern 5 streaming, then a mid-frame reset
        pat = 4'd5;
        tick();
        repeat (30) rand_pix();
        rst = 1'b1;
        pix(100, 50);
        rst = 1'b0;
        repeat (20) rand_pix();
        // request red mid-frame: nothing changes until the tick
        pat = 4'd0; tick();
        pat = 4'd1;
        for (int c = 0; c < 8; c++) pix(c * 50, 100);
        tick();
        pix(0, 0); pix(1, 0); pix(2, 0); pix(639, 479); pix(640, 0);
        // random pattern requests including illegal indices
        repeat (40) begin
            pat = 4'($urandom_range(0, 15));
            repeat (5) rand_pix();
            tick();
            repeat (25) rand_pix();
        end
        pat = 4'd12;
        tick();
        repeat (10) rand_pix();
        // bouncing box over 320 frames, probing its edges each frame
        pat = 4'd7;
        tick();
        repeat (320) begin
            tick();
            pix(m_bx, m_by);
            pix(m_bx + 31, m_by + 31);
            pix(m_bx + 32, m_by);
            pix(m_bx - 1, m_by + 5);
            pix(m_bx + 10, m_by + 32);
            rand_pix();
        end
        // scrolling bars through a full offset wrap
        pat = 4'd8;
        tick();
        repeat (170) begin
            pix(0, 10);
            pix(76, 10);
            rand_pix();
            tick();
        end
        // grey ramp including saturation and blanking
        pat = 4'd9;
        tick();
        pix(0, 5); pix(64, 5); pix(448, 5); pix(639, 5); pix(640, 5); pix(100, 479); pix(100, 480);
        repeat (20) rand_pix();
        pix(700, 500); pix(700, 500);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
